// File: rtl/tile_writer_pkg.sv
// Shared definitions for the 2048 board painter: geometry, FSM encoding and colours.
package tile_writer_pkg;

  localparam int unsigned TILE_SZ   = 16;
  localparam int unsigned FB_W      = 64;
  localparam int unsigned BOARD_N   = 4;
  localparam int unsigned FB_ADDR_W = 12;
  localparam int unsigned RGB_W     = 12;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned TILE_W    = 4;
  localparam int unsigned EXP_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PAINT = 2'd1,
    ST_FIN   = 2'd2
  } state_t;

  localparam logic [RGB_W-1:0] BORDER_RGB = 12'hBAA;

  // Entry n is the fill for exponent n; 12..15 all map to the saturated colour.
  localparam logic [15:0][RGB_W-1:0] PALETTE = {
    12'h333, 12'h333, 12'h333, 12'h333,
    12'hEC2, 12'hEC3, 12'hEC5, 12'hED6,
    12'hED7, 12'hF53, 12'hF75, 12'hF96,
    12'hFB7, 12'hEEC, 12'hEED, 12'hCCB
  };

endpackage

// File: rtl/tile_writer_palette.sv
// tile_palette: combinational exponent -> RGB444 fill colour lookup.
//  i_exp    4-bit tile exponent (>=12 saturates)
//  o_rgb_c  12-bit RGB444 fill colour
module tile_palette
  import tile_writer_pkg::*;
(
  input  logic [EXP_W-1:0] i_exp,
  output logic [RGB_W-1:0] o_rgb_c
);

  assign o_rgb_c = PALETTE[i_exp];

endmodule

// File: rtl/tile_writer.sv
// tile_writer: paints one 16x16 tile, or clears the whole 4x4 board, into the
// 64x64 RGB444 frame buffer at one pixel per clock.
//  clk, rst                 clock, synchronous active-high reset
//  cmd_valid/cmd_ready      command handshake (ready while idle)
//  cmd_clear/tile/exp       command payload, latched on accept
//  fb_we/fb_addr/fb_data    registered frame-buffer write port
//  busy                     painting in progress
//  done                     one-cycle pulse after the last write
module tile_writer
  import tile_writer_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_clear,
  input  logic [TILE_W-1:0]    cmd_tile,
  input  logic [EXP_W-1:0]     cmd_exp,
  output logic                 fb_we,
  output logic [FB_ADDR_W-1:0] fb_addr,
  output logic [RGB_W-1:0]     fb_data,
  output logic                 busy,
  output logic                 done
);

  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(TILE_SZ - 1);
  localparam logic [TILE_W-1:0] TILE_MAX = TILE_W'(BOARD_N * BOARD_N - 1);

  state_t r_state, w_state_nxt;

  logic [CNT_W-1:0]     r_x, r_y;
  logic [TILE_W-1:0]    r_tile;
  logic [EXP_W-1:0]     r_exp;
  logic                 r_clear;

  logic                 r_we, r_done, r_ready, r_busy;
  logic [FB_ADDR_W-1:0] r_addr;
  logic [RGB_W-1:0]     r_data;

  logic                 w_accept, w_last_px, w_border;
  logic [RGB_W-1:0]     w_pal;
  logic                 w_we_nxt, w_done_nxt, w_ready_nxt;
  logic [FB_ADDR_W-1:0] w_addr_nxt;
  logic [RGB_W-1:0]     w_data_nxt;

  assign w_accept  = cmd_valid & r_ready;
  assign w_last_px = (r_x == CNT_MAX) && (r_y == CNT_MAX);
  assign w_border  = (r_x == '0) || (r_x == CNT_MAX) || (r_y == '0) || (r_y == CNT_MAX);

  tile_palette u_palette (
    .i_exp   (r_exp),
    .o_rgb_c (w_pal)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_nxt = ST_PAINT;
      ST_PAINT: if (w_last_px && (!r_clear || (r_tile == TILE_MAX))) w_state_nxt = ST_FIN;
      ST_FIN:   w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Output decode: next values for the registered write port and status
  always_comb begin
    w_we_nxt    = 1'b0;
    w_addr_nxt  = r_addr;
    w_data_nxt  = r_data;
    w_done_nxt  = (r_state == ST_FIN);
    w_ready_nxt = (w_state_nxt == ST_IDLE);
    if (r_state == ST_PAINT) begin
      w_we_nxt   = 1'b1;
      // {ty, y, tx, x} is exactly row*64 + col for 16-pixel tiles on a 64-wide buffer
      w_addr_nxt = {r_tile[3:2], r_y, r_tile[1:0], r_x};
      w_data_nxt = w_border ? BORDER_RGB : w_pal;
    end
  end

  // Pixel/tile counters and latched command
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x     <= '0;
      r_y     <= '0;
      r_tile  <= '0;
      r_exp   <= '0;
      r_clear <= 1'b0;
    end else if (w_accept) begin
      r_x     <= '0;
      r_y     <= '0;
      r_tile  <= cmd_clear ? '0 : cmd_tile;
      r_exp   <= cmd_clear ? '0 : cmd_exp;
      r_clear <= cmd_clear;
    end else if (r_state == ST_PAINT) begin
      r_x <= r_x + CNT_W'(1);
      if (r_x == CNT_MAX) r_y <= r_y + CNT_W'(1);
      if (w_last_px && r_clear) r_tile <= r_tile + TILE_W'(1);
    end
  end

  // Registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_we    <= w_we_nxt;
      r_addr  <= w_addr_nxt;
      r_data  <= w_data_nxt;
      r_done  <= w_done_nxt;
      r_ready <= w_ready_nxt;
      r_busy  <= ~w_ready_nxt;
    end
  end

  assign fb_we     = r_we;
  assign fb_addr   = r_addr;
  assign fb_data   = r_data;
  assign done      = r_done;
  assign cmd_ready = r_ready;
  assign busy      = r_busy;

endmodule

// File: tb/tb_tile_writer.sv
// Bench for tile_writer: reference model of the painted pixel stream, table of
// probe points, and hand sequences for back-to-back requests and mid-paint reset.
module tb_tile_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_clear;
  logic [3:0]  cmd_tile;
  logic [3:0]  cmd_exp;
  logic        fb_we;
  logic [11:0] fb_addr;
  logic [11:0] fb_data;
  logic        busy;
  logic        done;

  tile_writer dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_clear (cmd_clear),
    .cmd_tile  (cmd_tile),
    .cmd_exp   (cmd_exp),
    .fb_we     (fb_we),
    .fb_addr   (fb_addr),
    .fb_data   (fb_data),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [11:0] log_addr [4096];
  logic [11:0] log_data [4096];
  int          log_n;

  typedef struct {
    logic        clr;
    logic [3:0]  tile;
    logic [3:0]  e;
    int          idx;
    logic [11:0] addr;
    logic [11:0] data;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [11:0] ref_fill(input int e);
    case (e)
      0: return 12'hCCB;  1: return 12'hEED;  2: return 12'hEEC;  3: return 12'hFB7;
      4: return 12'hF96;  5: return 12'hF75;  6: return 12'hF53;  7: return 12'hED7;
      8: return 12'hED6;  9: return 12'hEC5; 10: return 12'hEC3; 11: return 12'hEC2;
      default: return 12'h333;
    endcase
  endfunction

  function automatic logic [11:0] ref_color(input int x, input int y, input int e);
    if (x == 0 || x == 15 || y == 0 || y == 15) return 12'hBAA;
    return ref_fill(e);
  endfunction

  function automatic logic [11:0] ref_addr(input int t, input int x, input int y);
    return 12'((((t / 4) * 16 + y) * 64) + (t % 4) * 16 + x);
  endfunction

  // Issue one command and check every cycle up to (and just past) its done pulse.
  // abort_n>0 asserts rst after that many writes; hold_next raises the next
  // request at k+10 so it waits for the current command to finish.
  task automatic do_cmd(input logic clr, input logic [3:0] t, input logic [3:0] e,
                        input int abort_n, input logic hold_next,
                        input logic [3:0] nt, input logic [3:0] ne, input string nm);
    logic [11:0] ea[$];
    logic [11:0] ed[$];
    int          n_px, w, bad, first_bad, distinct;
    logic [11:0] fa, fd, fea, fed;
    logic        fwe;
    bit          seen [4096];

    n_px = clr ? 4096 : 256;
    for (int tt = 0; tt < 16; tt++)
      if (clr || tt == int'(t))
        for (int y = 0; y < 16; y++)
          for (int x = 0; x < 16; x++) begin
            ea.push_back(ref_addr(tt, x, y));
            ed.push_back(ref_color(x, y, clr ? 0 : int'(e)));
          end

    @(negedge clk);
    cmd_valid = 1'b1; cmd_clear = clr; cmd_tile = t; cmd_exp = e;
    w = 0;
    while (!cmd_ready && w < 10000) begin @(negedge clk); w++; end
    if (!cmd_ready) begin
      check({nm, " accept timeout"}, 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_clear = 1'($urandom); cmd_tile = 4'($urandom); cmd_exp = 4'($urandom);
    check({nm, " accept busy"}, 32'(busy), 32'd1);
    check({nm, " accept we"}, 32'(fb_we), 32'd0);

    bad = 0; first_bad = -1; log_n = 0;
    fwe = 0; fa = 0; fd = 0; fea = 0; fed = 0;
    for (int n = 1; n <= n_px; n++) begin
      @(posedge clk); #1;
      if (hold_next && n == 10) begin
        cmd_valid = 1'b1; cmd_clear = 1'b0; cmd_tile = nt; cmd_exp = ne;
      end else if (!(hold_next && n > 10)) begin
        cmd_tile = 4'($urandom); cmd_exp = 4'($urandom);
      end
      if (fb_we === 1'b1 && log_n < 4096) begin
        log_addr[log_n] = fb_addr; log_data[log_n] = fb_data; log_n++;
      end
      if (!(fb_we === 1'b1 && fb_addr === ea[n-1] && fb_data === ed[n-1] &&
            busy === 1'b1 && cmd_ready === 1'b0 && done === 1'b0)) begin
        if (bad == 0) begin
          first_bad = n; fwe = fb_we; fa = fb_addr; fd = fb_data; fea = ea[n-1]; fed = ed[n-1];
        end
        bad++;
      end
      if (n == abort_n) begin
        rst = 1'b1;
        @(posedge clk); #1;
        check({nm, " rst we"}, 32'(fb_we), 32'd0);
        check({nm, " rst busy"}, 32'(busy), 32'd0);
        check({nm, " rst ready"}, 32'(cmd_ready), 32'd1);
        check({nm, " rst done"}, 32'(done), 32'd0);
        @(negedge clk); rst = 1'b0;
        w = 0;
        repeat (4) begin
          @(posedge clk); #1;
          if (done !== 1'b0 || fb_we !== 1'b0) w++;
        end
        check({nm, " post-rst idle"}, 32'(w), 32'd0);
        break;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s pixels: %0d bad cycles, first #%0d got we=%b addr=%h data=%h expected we=1 addr=%h data=%h",
               nm, bad, first_bad, fwe, fa, fd, fea, fed);
    end
    if (abort_n > 0) return;

    @(posedge clk); #1;
    check({nm, " end we"}, 32'(fb_we), 32'd0);
    check({nm, " end done"}, 32'(done), 32'd1);
    check({nm, " end ready"}, 32'(cmd_ready), 32'd1);
    check({nm, " end busy"}, 32'(busy), 32'd0);
    if (!hold_next) begin
      @(posedge clk); #1;
      check({nm, " done width"}, 32'(done), 32'd0);
    end
    check({nm, " write count"}, 32'(log_n), 32'(n_px));
    if (clr) begin
      distinct = 0;
      for (int i = 0; i < log_n; i++)
        if (!seen[log_addr[i]]) begin seen[log_addr[i]] = 1'b1; distinct++; end
      check({nm, " distinct addrs"}, 32'(distinct), 32'd4096);
    end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_clear = 1'b0; cmd_tile = '0; cmd_exp = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset we", 32'(fb_we), 32'd0);
    check("reset addr", 32'(fb_addr), 32'd0);
    check("reset data", 32'(fb_data), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset ready", 32'(cmd_ready), 32'd1);
    @(negedge clk); rst = 1'b0;

    // probe points: index into the write log is the order of writing
    vecs[0] = '{1'b0, 4'd5,  4'd1,  0,         12'h410, 12'hBAA};
    vecs[1] = '{1'b0, 4'd5,  4'd1,  5*16+5,    12'h555, 12'hEED};
    vecs[2] = '{1'b0, 4'd5,  4'd1,  255,       12'h7DF, 12'hBAA};
    vecs[3] = '{1'b0, 4'd0,  4'd13, 0,         12'h000, 12'hBAA};
    vecs[4] = '{1'b0, 4'd0,  4'd13, 4*16+3,    12'h103, 12'h333};
    vecs[5] = '{1'b0, 4'd15, 4'd11, 8*16+8,    12'hE38, 12'hEC2};
    vecs[6] = '{1'b0, 4'd15, 4'd11, 255,       12'hFFF, 12'hBAA};
    vecs[7] = '{1'b1, 4'd9,  4'd7,  5*16+5,    12'h145, 12'hCCB};

    for (int i = 0; i < 8; i++) begin
      do_cmd(vecs[i].clr, vecs[i].tile, vecs[i].e, 0, 1'b0, 4'd0, 4'd0, $sformatf("vec%0d", i));
      check($sformatf("vec%0d addr", i), 32'(log_addr[vecs[i].idx]), 32'(vecs[i].addr));
      check($sformatf("vec%0d data", i), 32'(log_data[vecs[i].idx]), 32'(vecs[i].data));
    end

    // request held while busy: accepted the edge after done, writes one edge later
    do_cmd(1'b0, 4'd2, 4'd3, 0, 1'b1, 4'd6, 4'd4, "hold first");
    do_cmd(1'b0, 4'd6, 4'd4, 0, 1'b0, 4'd0, 4'd0, "hold second");

    // reset at the 100th write of tile 3, then a clean repeat
    do_cmd(1'b0, 4'd3, 4'd5, 100, 1'b0, 4'd0, 4'd0, "abort");
    do_cmd(1'b0, 4'd3, 4'd5, 0, 1'b0, 4'd0, 4'd0, "after abort");

    for (int i = 0; i < 6; i++)
      do_cmd(1'b0, 4'($urandom), 4'($urandom), 0, 1'b0, 4'd0, 4'd0, $sformatf("rand%0d", i));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
